// File: rtl/pad_pkg.sv
// Shared types and constants for the serial game-pad poll sequencer.
// Button bit positions follow the pad's shift order: A is shifted out first.
package pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        PULSE_HI,
        PULSE_LO,
        DONE
    } state_t;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef logic [$clog2(NUM_BUTTONS)-1:0] bit_idx_t;

    function automatic logic is_last_bit(input bit_idx_t idx);
        return idx == bit_idx_t'(NUM_BUTTONS - 1);
    endfunction

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchroniser for the asynchronous pad data line.
// Resets to 1, the released (not pressed) level of the active-low pad data.
module pad_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_poll_sequencer.sv
// Scheduled poller for a latch/pulse/data serial game pad: drives latch and pulse,
// deserialises 8 button bits and publishes them as one atomic active-high word.
module pad_poll_sequencer
    import pad_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_PERIOD  = 300,
    parameter int POLL_PERIOD  = 833333
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       poll_now,
    input  logic       data_in,
    output logic       latch,
    output logic       pulse,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int PHASE_W   = $clog2(PHASE_MAX);
    localparam int TIMER_W   = $clog2(POLL_PERIOD);

    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_PERIOD - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);

    state_t                 state;
    state_t                 state_next;
    logic [PHASE_W-1:0]     phase_cnt;
    logic                   phase_last;
    bit_idx_t               bit_idx;
    logic [NUM_BUTTONS-1:0] shift_reg;
    logic [TIMER_W-1:0]     timer;
    logic                   pending;
    logic                   tick;
    logic                   request;
    logic                   leave_idle;
    logic                   capture;
    logic                   data_sync;

    pad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (data_in),
        .q   (data_sync)
    );

    assign tick       = enable && (timer == TIMER_LAST);
    assign request    = tick || (enable && poll_now);
    assign leave_idle = (state == IDLE) && pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (!enable || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end

    // A request arriving in the same cycle the FSM leaves IDLE stays pending for the next poll.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (!enable) begin
            pending <= 1'b0;
        end else if (request) begin
            pending <= 1'b1;
        end else if (leave_idle) begin
            pending <= 1'b0;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        phase_last = 1'b0;
        case (state)
            IDLE: begin
                if (pending) state_next = LATCH;
            end
            LATCH: begin
                phase_last = (phase_cnt == LATCH_LAST);
                if (phase_last) state_next = PULSE_HI;
            end
            PULSE_HI: begin
                phase_last = (phase_cnt == HALF_LAST);
                if (phase_last) state_next = PULSE_LO;
            end
            PULSE_LO: begin
                phase_last = (phase_cnt == HALF_LAST);
                if (phase_last) state_next = is_last_bit(bit_idx) ? DONE : PULSE_HI;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign capture = phase_last && ((state == LATCH) || (state == PULSE_LO));

    // latch/pulse are registered from the next state so the pad pins never see decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_idx   <= '0;
            shift_reg <= '1;
            buttons   <= 8'h00;
            latch     <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            state <= state_next;
            latch <= (state_next == LATCH);
            pulse <= (state_next == PULSE_HI);

            if ((state_next != state) || (state == IDLE)) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + PHASE_W'(1);
            end

            if (state == IDLE) begin
                bit_idx <= '0;
            end else if (capture) begin
                shift_reg[bit_idx] <= data_sync;
                bit_idx            <= bit_idx + bit_idx_t'(1);
            end

            // The final bit is folded in directly so the word is already complete during DONE.
            if ((state == PULSE_LO) && (state_next == DONE)) begin
                buttons <= ~{data_sync, shift_reg[NUM_BUTTONS-2:0]};
            end
        end
    end

    assign valid = (state == DONE);
    assign busy  = (state != IDLE);

endmodule
